// File: rtl/sva_seq_pkg.sv
// Shared types for the multi-thread sequence checker: slot record, per-step
// result codes and a popcount helper.
package sva_seq_pkg;

    // Slot geometry is fixed here; top-level overrides must agree with it.
    localparam int SEQ_STEPS    = 3;
    localparam int SEQ_MAX_WAIT = 2;
    localparam int SEQ_TW       = 16;
    localparam logic [SEQ_STEPS-1:0] SEQ_WAIT_MASK = 3'b010;

    localparam int STEP_W = (SEQ_STEPS > 1) ? $clog2(SEQ_STEPS) : 1;
    localparam int WAIT_W = $clog2(SEQ_MAX_WAIT + 1);

    typedef struct packed {
        logic              active;
        logic [STEP_W-1:0] step;
        logic [WAIT_W-1:0] wait_cnt;
        logic [SEQ_TW-1:0] stamp;
    } slot_t;

    typedef enum logic [2:0] {R_HOLD, R_ADV, R_WAIT, R_PASS, R_FAIL} result_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/sva_seq_slot.sv
// One thread's combinational step evaluation: next slot state and result.
module sva_seq_slot
    import sva_seq_pkg::*;
#(
    parameter int                   NUM_STEPS = SEQ_STEPS,
    parameter int                   MAX_WAIT  = SEQ_MAX_WAIT,
    parameter logic [NUM_STEPS-1:0] WAIT_MASK = SEQ_WAIT_MASK
) (
    input  slot_t                cur,
    input  logic [NUM_STEPS-1:0] step_match,
    output slot_t                nxt,
    output result_e              res
);

    always_comb begin
        nxt = cur;
        res = R_HOLD;
        if (cur.active) begin
            if (step_match[cur.step]) begin
                if (cur.step == STEP_W'(NUM_STEPS - 1)) begin
                    res        = R_PASS;
                    nxt.active = 1'b0;
                end else begin
                    res          = R_ADV;
                    nxt.step     = cur.step + 1'b1;
                    nxt.wait_cnt = '0;
                end
            end else if (WAIT_MASK[cur.step] && (cur.wait_cnt < WAIT_W'(MAX_WAIT))) begin
                res          = R_WAIT;
                nxt.wait_cnt = cur.wait_cnt + 1'b1;
            end else begin
                res        = R_FAIL;
                nxt.active = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sva_seq_engine.sv
// Parallel multi-thread sequence property checker, evaluated on sampled
// gclk rising edges; owns slot registers, allocation and event counters.
module sva_seq_engine
    import sva_seq_pkg::*;
#(
    parameter int                   NUM_STEPS   = SEQ_STEPS,
    parameter int                   THREADS     = 4,
    parameter int                   MAX_WAIT    = SEQ_MAX_WAIT,
    parameter logic [NUM_STEPS-1:0] WAIT_MASK   = SEQ_WAIT_MASK,
    parameter int                   TIMER_WIDTH = SEQ_TW,
    parameter int                   CNT_W       = 16,
    localparam int                  AW          = $clog2(THREADS + 1),
    localparam int                  IW          = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   gclk,
    input  logic                   grst,
    input  logic                   enable,
    input  logic                   trigger,
    input  logic [NUM_STEPS-1:0]   step_match,
    output logic                   succ,
    output logic                   fail,
    output logic                   ovf,
    output logic [TIMER_WIDTH-1:0] fail_stamp,
    output logic                   busy,
    output logic [AW-1:0]          active_cnt,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [CNT_W-1:0]       ovf_cnt
);

    logic                   gclk_d0, gclk_d1, tick;
    logic [TIMER_WIDTH-1:0] tick_cnt;
    slot_t [THREADS-1:0]    slot_q, slot_nxt, slot_d;
    result_e                slot_res [THREADS];
    slot_t                  spawn_cur, spawn_nxt;
    result_e                spawn_res;
    logic                   spawn_keep, free_found, ovf_now;
    logic [IW-1:0]          free_idx;
    logic [THREADS:0]       pass_vec, fail_vec;
    logic [THREADS-1:0]     act_q, act_d;
    logic [TIMER_WIDTH-1:0] best_stamp, best_age, age;
    logic                   best_found;
    logic [CNT_W:0]         pass_sum, fail_sum, ovf_sum;

    assign tick = gclk_d0 & ~gclk_d1 & ~grst;

    always_comb begin
        spawn_cur        = '0;
        spawn_cur.active = tick & trigger & enable;
        spawn_cur.stamp  = tick_cnt;
    end

    sva_seq_slot #(.NUM_STEPS(NUM_STEPS), .MAX_WAIT(MAX_WAIT), .WAIT_MASK(WAIT_MASK)) u_spawn (
        .cur(spawn_cur), .step_match(step_match), .nxt(spawn_nxt), .res(spawn_res)
    );

    for (genvar g = 0; g < THREADS; g++) begin : g_slot
        sva_seq_slot #(.NUM_STEPS(NUM_STEPS), .MAX_WAIT(MAX_WAIT), .WAIT_MASK(WAIT_MASK)) u_slot (
            .cur(slot_q[g]), .step_match(step_match), .nxt(slot_nxt[g]), .res(slot_res[g])
        );
        assign act_q[g] = slot_q[g].active;
        assign act_d[g] = slot_d[g].active;
    end

    assign busy       = |act_q;
    assign spawn_keep = (spawn_res == R_ADV) || (spawn_res == R_WAIT);
    assign ovf_now    = spawn_keep & ~free_found;

    // Only slots idle at the start of the tick are candidates for a spawn.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (!slot_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        pass_vec[THREADS] = (spawn_res == R_PASS);
        fail_vec[THREADS] = (spawn_res == R_FAIL);
        for (int i = 0; i < THREADS; i++) begin
            pass_vec[i] = (slot_res[i] == R_PASS);
            fail_vec[i] = (slot_res[i] == R_FAIL);
            slot_d[i]   = slot_nxt[i];
            if (spawn_keep && free_found && (free_idx == IW'(i))) slot_d[i] = spawn_nxt;
        end
    end

    // Oldest failing thread wins, age measured modulo the tick counter.
    always_comb begin
        best_found = fail_vec[THREADS];
        best_stamp = tick_cnt;
        best_age   = '0;
        age        = '0;
        for (int i = 0; i < THREADS; i++) begin
            age = tick_cnt - slot_q[i].stamp;
            if (fail_vec[i] && (!best_found || age > best_age)) begin
                best_found = 1'b1;
                best_age   = age;
                best_stamp = slot_q[i].stamp;
            end
        end
    end

    assign pass_sum = {1'b0, pass_cnt} + (CNT_W+1)'(popcount(32'(pass_vec)));
    assign fail_sum = {1'b0, fail_cnt} + (CNT_W+1)'(popcount(32'(fail_vec)));
    assign ovf_sum  = {1'b0, ovf_cnt}  + (CNT_W+1)'(ovf_now);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gclk_d0    <= 1'b0;
            gclk_d1    <= 1'b0;
            tick_cnt   <= '0;
            slot_q     <= '0;
            succ       <= 1'b0;
            fail       <= 1'b0;
            ovf        <= 1'b0;
            fail_stamp <= '0;
            active_cnt <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            ovf_cnt    <= '0;
        end else if (grst) begin
            gclk_d0    <= 1'b0;
            gclk_d1    <= 1'b0;
            tick_cnt   <= '0;
            slot_q     <= '0;
            succ       <= 1'b0;
            fail       <= 1'b0;
            ovf        <= 1'b0;
            active_cnt <= '0;
        end else begin
            gclk_d0 <= gclk;
            gclk_d1 <= gclk_d0;
            succ    <= 1'b0;
            fail    <= 1'b0;
            ovf     <= 1'b0;
            if (tick) begin
                tick_cnt   <= tick_cnt + 1'b1;
                slot_q     <= slot_d;
                active_cnt <= AW'(popcount(32'(act_d)));
                succ       <= |pass_vec;
                fail       <= |fail_vec;
                ovf        <= ovf_now;
                pass_cnt   <= pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
                fail_cnt   <= fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
                ovf_cnt    <= ovf_sum[CNT_W]  ? '1 : ovf_sum[CNT_W-1:0];
                if (|fail_vec) fail_stamp <= best_stamp;
            end
        end
    end

endmodule

// File: tb/tb_sva_seq_engine.sv
// Directed bench for sva_seq_engine with hand-computed expectations.
module tb_sva_seq_engine;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n, gclk, grst, enable, trigger;
    logic [2:0]  step_match;
    logic        succ, fail, ovf, busy;
    logic [15:0] fail_stamp, pass_cnt, fail_cnt, ovf_cnt;
    logic [2:0]  active_cnt;
    logic        s_succ, s_fail, s_ovf;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    sva_seq_engine dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gclk(gclk), .grst(grst),
        .enable(enable), .trigger(trigger), .step_match(step_match),
        .succ(succ), .fail(fail), .ovf(ovf), .fail_stamp(fail_stamp),
        .busy(busy), .active_cnt(active_cnt),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .ovf_cnt(ovf_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One gclk rising edge; pulses captured in the cycle after evaluation.
    task automatic do_tick(input logic trg, input logic en, input logic [2:0] sm);
        @(negedge sys_clk);
        gclk = 1'b1; trigger = trg; enable = en; step_match = sm;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        s_succ = succ; s_fail = fail; s_ovf = ovf;
        @(negedge sys_clk);
        gclk = 1'b0; trigger = 1'b0; step_match = 3'b000;
        @(posedge sys_clk);
        @(posedge sys_clk);
    endtask

    task automatic chk_ev(input string tag, input logic es, input logic ef, input logic eo);
        chk({tag, ".succ"}, 32'(s_succ), 32'(es));
        chk({tag, ".fail"}, 32'(s_fail), 32'(ef));
        chk({tag, ".ovf"},  32'(s_ovf),  32'(eo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0; gclk = 1'b0; grst = 1'b0; enable = 1'b0;
        trigger = 1'b0; step_match = 3'b000;
        #12;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.active", 32'(active_cnt), 0);
        chk("rst.pulses", 32'({succ, fail, ovf}), 0);
        chk("rst.cnts", 32'(pass_cnt | fail_cnt | ovf_cnt | fail_stamp), 0);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        // single pass, ticks 0..2
        do_tick(1, 1, 3'b001);
        chk_ev("p0", 0, 0, 0);
        chk("p0.active", 32'(active_cnt), 1);
        chk("p0.busy", 32'(busy), 1);
        do_tick(0, 1, 3'b010);
        do_tick(0, 1, 3'b100);
        chk_ev("p2", 1, 0, 0);
        chk("p2.pass_cnt", 32'(pass_cnt), 1);
        chk("p2.busy", 32'(busy), 0);
        chk("p2.succ_clr", 32'(succ), 0);

        // bounded wait passes after two misses, ticks 3..7
        do_tick(1, 1, 3'b001);
        do_tick(0, 1, 3'b000);
        do_tick(0, 1, 3'b000);
        chk_ev("w2", 0, 0, 0);
        do_tick(0, 1, 3'b010);
        do_tick(0, 1, 3'b100);
        chk_ev("wpass", 1, 0, 0);
        chk("wpass.pass_cnt", 32'(pass_cnt), 2);

        // three misses fail, spawn at tick 8
        do_tick(1, 1, 3'b001);
        do_tick(0, 1, 3'b000);
        do_tick(0, 1, 3'b000);
        do_tick(0, 1, 3'b000);
        chk_ev("wfail", 0, 1, 0);
        chk("wfail.stamp", 32'(fail_stamp), 8);
        chk("wfail.fail_cnt", 32'(fail_cnt), 1);

        // immediate fail at tick 12, never occupies a slot
        do_tick(1, 1, 3'b000);
        chk_ev("imm", 0, 1, 0);
        chk("imm.stamp", 32'(fail_stamp), 12);
        chk("imm.fail_cnt", 32'(fail_cnt), 2);
        chk("imm.active", 32'(active_cnt), 0);

        // disabled spawn at tick 13
        do_tick(1, 0, 3'b001);
        chk("dis.active", 32'(active_cnt), 0);
        chk_ev("dis", 0, 0, 0);

        // fill all four slots, ticks 14..17
        do_tick(1, 1, 3'b001);
        do_tick(1, 1, 3'b001);
        do_tick(1, 1, 3'b001);
        do_tick(1, 1, 3'b011);
        chk("full.active", 32'(active_cnt), 4);
        // tick 18: three slots fail together, spawn finds no free slot
        do_tick(1, 1, 3'b011);
        chk_ev("ovf", 0, 1, 1);
        chk("ovf.ovf_cnt", 32'(ovf_cnt), 1);
        chk("sim.fail_cnt", 32'(fail_cnt), 5);
        chk("sim.stamp", 32'(fail_stamp), 14);
        chk("sim.active", 32'(active_cnt), 1);
        // tick 19: last old thread fails, new one reuses the freed slot
        do_tick(1, 1, 3'b011);
        chk_ev("reuse", 0, 1, 0);
        chk("reuse.stamp", 32'(fail_stamp), 17);
        chk("reuse.active", 32'(active_cnt), 1);
        do_tick(0, 1, 3'b010);
        do_tick(0, 1, 3'b100);
        chk_ev("reuse.pass", 1, 0, 0);
        chk("reuse.pass_cnt", 32'(pass_cnt), 3);

        // grst with three live threads, ticks 22..24
        do_tick(1, 1, 3'b001);
        do_tick(1, 1, 3'b001);
        do_tick(1, 1, 3'b001);
        chk("pre_grst.active", 32'(active_cnt), 3);
        @(negedge sys_clk); grst = 1'b1;
        @(posedge sys_clk); #1;
        chk("grst.active", 32'(active_cnt), 0);
        chk("grst.busy", 32'(busy), 0);
        chk("grst.pass_cnt", 32'(pass_cnt), 3);
        chk("grst.fail_cnt", 32'(fail_cnt), 6);
        chk("grst.ovf_cnt", 32'(ovf_cnt), 1);
        chk("grst.stamp", 32'(fail_stamp), 17);
        @(negedge sys_clk); grst = 1'b0;
        // tick counter restarted from zero
        do_tick(1, 1, 3'b000);
        chk("post_grst.stamp", 32'(fail_stamp), 0);
        chk("post_grst.fail_cnt", 32'(fail_cnt), 7);

        // async reset between clock edges
        @(negedge sys_clk); #1;
        sys_rst_n = 1'b0;
        #1;
        chk("arst.pass_cnt", 32'(pass_cnt), 0);
        chk("arst.fail_cnt", 32'(fail_cnt), 0);
        chk("arst.ovf_cnt", 32'(ovf_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
